vga_sync_receiver: RTL

//  Receiving end of the 640x480 VGA link: samples hSync/vSync/RGB driven by the display path,

---
 rtl/vga_sync_receiver.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vga_sync_receiver.sv
// VGA link receiver: locks to incoming hSync/vSync, recovers pixel coordinates/colour, flags timing faults.
// Optional VGA_RX_CHECKSUM_EN: per-frame 24-bit sum of active-pixel colour on frame_sum.
module vga_sync_receiver #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [3:0]  VGA_R,
    input  logic [3:0]  VGA_G,
    input  logic [3:0]  VGA_B,
    output logic [9:0]  rx_x,
    output logic [8:0]  rx_y,
    output logic        rx_active,
    output logic [11:0] rx_color,
    output logic        frame_start,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [23:0] frame_sum
);
    localparam logic [10:0] H_TOTAL = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [10:0] V_TOTAL = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [10:0] X0      = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] Y0      = 11'(V_SYNC + V_BACK);

    typedef enum logic [1:0] {SEARCH, WAIT_V, TRACK, LOCK} state_t;
    state_t state, state_nxt;
    logic [7:0]  good, good_nxt;

    logic        hs_q, vs_q, pix_d;
    logic [11:0] rgb_q;
    logic [9:0]  h_cnt, v_cnt;
    logic        h_fall, h_rise, v_fall, v_rise, h_bad, v_bad, armed;
    logic [10:0] h_len, lines, x11, y11;
    logic        in_win;

    assign h_fall = pix_en &  hs_q & ~hSync;
    assign h_rise = pix_en & ~hs_q &  hSync;
    assign v_fall = pix_en &  vs_q & ~vSync;
    assign v_rise = pix_en & ~vs_q &  vSync;

    // Line count includes a line edge sampled together with the frame edge.
    assign h_len = {1'b0, h_cnt} + 11'd1;
    assign lines = {1'b0, v_cnt} + {10'd0, h_fall};
    assign h_bad = (h_fall && h_len != H_TOTAL) || (h_rise && h_len != 11'(H_SYNC));
    assign v_bad = (v_fall && lines != V_TOTAL) || (v_rise && lines != 11'(V_SYNC));
    assign armed = (state == TRACK) || (state == LOCK);
    assign locked = (state == LOCK);

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        case (state)
            SEARCH: if (h_fall) begin
                state_nxt = v_fall ? TRACK : WAIT_V;
                good_nxt  = 8'd0;
            end
            WAIT_V: if (v_fall) begin
                state_nxt = TRACK;
                good_nxt  = 8'd0;
            end
            TRACK: if (h_bad || v_bad) begin
                state_nxt = WAIT_V;
            end else if (v_fall) begin
                good_nxt = good + 8'd1;
                if (good + 8'd1 >= 8'(LOCK_FRAMES)) state_nxt = LOCK;
            end
            LOCK: if (h_bad || v_bad) state_nxt = WAIT_V;
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SEARCH;
            good        <= 8'd0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            rgb_q       <= 12'd0;
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            pix_d       <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            good        <= good_nxt;
            pix_d       <= pix_en;
            h_err       <= armed & h_bad;
            v_err       <= armed & v_bad;
            frame_start <= v_fall;
            if (pix_en) begin
                hs_q  <= hSync;
                vs_q  <= vSync;
                rgb_q <= {VGA_R, VGA_G, VGA_B};
                if (h_fall)             h_cnt <= 10'd0;
                else if (h_cnt != '1)   h_cnt <= h_cnt + 10'd1;
                if (v_fall)                     v_cnt <= 10'd0;
                else if (h_fall && v_cnt != '1) v_cnt <= v_cnt + 10'd1;
            end
        end
    end

    // Counters already describe the sampled pixel one clk after pix_en.
    assign x11    = {1'b0, h_cnt} - X0;
    assign y11    = {1'b0, v_cnt} - Y0;
    assign in_win = ({1'b0, h_cnt} >= X0) && (x11 < 11'(H_ACTIVE)) &&
                    ({1'b0, v_cnt} >= Y0) && (y11 < 11'(V_ACTIVE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_x      <= 10'd0;
            rx_y      <= 9'd0;
            rx_color  <= 12'd0;
            rx_active <= 1'b0;
        end else if (pix_d) begin
            rx_active <= in_win & locked;
            if (in_win) begin
                rx_x     <= x11[9:0];
                rx_y     <= y11[8:0];
                rx_color <= rgb_q;
            end
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [23:0] acc, acc_nxt;
    assign acc_nxt = acc + ((pix_d && in_win) ? {12'd0, rgb_q} : 24'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= 24'd0;
            frame_sum <= 24'd0;
        end else if (v_fall) begin
            frame_sum <= acc_nxt;
            acc       <= 24'd0;
        end else begin
            acc <= acc_nxt;
        end
    end
`else
    assign frame_sum = 24'd0;
`endif

endmodule
